// File: rtl/filter_pkg.sv
// Shared definitions for the audio filter datapath: sequencer state encoding
// and the default sample / sample-RAM address widths used by filter_fsm too.
package filter_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int PTR_W_DEF  = 5;

    typedef enum logic [2:0] {
        IDLE,
        START_CONV,
        WAIT_INT,
        READ,
        WRITE,
        KICK,
        ARM,
        RUN
    } seq_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator: one-cycle tick every CLK_DIV clocks while enabled.
module sample_tick_gen #(
    parameter int unsigned CLK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] tcnt;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            tcnt <= '0;
        end else if (tcnt == LAST) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 16'd1;
        end
    end

    assign tick = enable && (tcnt == LAST);

endmodule

// File: rtl/sample_sequencer.sv
// Per-sample sequencer: A/D convert, read, write into the circular sample RAM,
// then start the convolution FSM and wait for it; flags overrun and A/D timeout.
module sample_sequencer
    import filter_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 1000,
    parameter int unsigned WR_CYCLES    = 2,
    parameter int unsigned RD_CYCLES    = 3,
    parameter int unsigned CONV_TIMEOUT = 255,
    parameter int          DATA_W       = DATA_W_DEF,
    parameter int          PTR_W        = PTR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_flags,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_intb,
    output logic              adc_wrb,
    output logic              adc_rdb,
    output logic [PTR_W-1:0]  ram_ptr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wr,
    output logic              filter_start,
    input  logic              filter_busy,
    output logic              overrun,
    output logic              adc_timeout
);

    localparam logic [15:0] WR_LAST = 16'(WR_CYCLES - 1);
    localparam logic [15:0] RD_LAST = 16'(RD_CYCLES - 1);
    localparam logic [15:0] TO_LAST = 16'(CONV_TIMEOUT - 1);

    seq_state_t  state;
    logic [15:0] cnt;
    logic        tick;

    sample_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .tick  (tick)
    );

    // Strobes are loaded on the transition into a state so that, being
    // registered, they are high exactly during that state (ram_wr in WRITE,
    // filter_start in KICK).
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            adc_wrb      <= 1'b1;
            adc_rdb      <= 1'b1;
            ram_ptr      <= '1;
            ram_wdata    <= '0;
            ram_wr       <= 1'b0;
            filter_start <= 1'b0;
            overrun      <= 1'b0;
            adc_timeout  <= 1'b0;
        end else begin
            ram_wr       <= 1'b0;
            filter_start <= 1'b0;

            if (clear_flags) begin
                overrun     <= 1'b0;
                adc_timeout <= 1'b0;
            end
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        adc_wrb <= 1'b0;
                        cnt     <= '0;
                        state   <= START_CONV;
                    end
                end
                START_CONV: begin
                    if (cnt == WR_LAST) begin
                        adc_wrb <= 1'b1;
                        cnt     <= '0;
                        state   <= WAIT_INT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_INT: begin
                    if (!adc_intb) begin
                        adc_rdb <= 1'b0;
                        cnt     <= '0;
                        state   <= READ;
                    end else if (cnt == TO_LAST) begin
                        adc_timeout <= 1'b1;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                READ: begin
                    if (cnt == RD_LAST) begin
                        ram_wdata <= adc_data;
                        adc_rdb   <= 1'b1;
                        ram_ptr   <= ram_ptr + PTR_W'(1);
                        ram_wr    <= 1'b1;
                        cnt       <= '0;
                        state     <= WRITE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WRITE: begin
                    filter_start <= 1'b1;
                    state        <= KICK;
                end
                KICK: begin
                    state <= ARM;
                end
                ARM: begin
                    state <= RUN;
                end
                RUN: begin
                    if (!filter_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer with a behavioural A/D converter and filter model;
// RAM writes are checked against a scoreboard of samples handed out by the A/D model.
module tb_sample_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clear_flags = 1'b0;
    logic [7:0] adc_data = 8'h00;
    logic       adc_intb = 1'b1;
    logic       adc_wrb;
    logic       adc_rdb;
    logic [4:0] ram_ptr;
    logic [7:0] ram_wdata;
    logic       ram_wr;
    logic       filter_start;
    logic       filter_busy = 1'b0;
    logic       overrun;
    logic       adc_timeout;

    always #5 clk = ~clk;

    sample_sequencer #(
        .CLK_DIV     (20),
        .WR_CYCLES   (2),
        .RD_CYCLES   (3),
        .CONV_TIMEOUT(10),
        .DATA_W      (8),
        .PTR_W       (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clear_flags (clear_flags),
        .adc_data    (adc_data),
        .adc_intb    (adc_intb),
        .adc_wrb     (adc_wrb),
        .adc_rdb     (adc_rdb),
        .ram_ptr     (ram_ptr),
        .ram_wdata   (ram_wdata),
        .ram_wr      (ram_wr),
        .filter_start(filter_start),
        .filter_busy (filter_busy),
        .overrun     (overrun),
        .adc_timeout (adc_timeout)
    );

    // Model controls, written only by the stimulus process
    logic [7:0] adc_value = 8'h5A;
    logic       adc_dead = 1'b0;
    int         busy_len = 8;

    typedef struct packed {
        logic [4:0] ptr;
        logic [7:0] data;
    } wr_t;

    wr_t        sbq[$];
    logic [4:0] next_ptr = 5'd0;
    int         adc_cd = 0;
    int         busy_cnt = 0;
    logic       prev_wrb = 1'b1;
    logic       prev_rdb = 1'b1;
    int         wr_count = 0;
    int         start_count = 0;
    int         sb_bad = 0;

    int pcount = 0;
    int base = 0;
    int tests = 0;
    int fails = 0;

    always @(posedge clk) pcount <= pcount + 1;

    // Monitor first (sees this cycle's inputs), then A/D and filter models.
    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
            next_ptr    = 5'd0;
            adc_cd      = 0;
            adc_intb    = 1'b1;
            filter_busy = 1'b0;
            busy_cnt    = 0;
            prev_wrb    = 1'b1;
            prev_rdb    = 1'b1;
        end else begin
            if (ram_wr) begin
                wr_t e;
                wr_count++;
                if (sbq.size() == 0) begin
                    sb_bad++;
                    $display("FAIL ram_wr_unexpected: got ptr=%0d data=%02h, required no write",
                             ram_ptr, ram_wdata);
                end else begin
                    e = sbq.pop_front();
                    if ({ram_ptr, ram_wdata} !== e) begin
                        sb_bad++;
                        $display("FAIL ram_write: got ptr=%0d data=%02h, required ptr=%0d data=%02h",
                                 ram_ptr, ram_wdata, e.ptr, e.data);
                    end
                end
                if (filter_start || filter_busy) begin
                    sb_bad++;
                    $display("FAIL ram_wr_exclusive: got start=%b busy=%b, required 0 0",
                             filter_start, filter_busy);
                end
            end
            if (filter_start) start_count++;

            if (!prev_wrb && adc_wrb && !adc_dead) begin
                adc_cd = 3;
            end else if (adc_cd > 0) begin
                adc_cd--;
                if (adc_cd == 0) adc_intb = 1'b0;
            end
            if (prev_rdb && !adc_rdb) begin
                adc_intb = 1'b1;
                adc_data = adc_value;
                sbq.push_back({next_ptr, adc_value});
                next_ptr = next_ptr + 5'd1;
            end

            if (filter_busy) begin
                busy_cnt--;
                if (busy_cnt == 0) filter_busy = 1'b0;
            end
            if (filter_start) begin
                filter_busy = 1'b1;
                busy_cnt    = busy_len;
            end

            prev_wrb = adc_wrb;
            prev_rdb = adc_rdb;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycle(input int n);
        while (pcount - base < n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start_run(input logic en);
        reset       = 1'b1;
        enable      = en;
        clear_flags = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        base  = pcount;
    endtask

    typedef struct {
        int          cyc;
        logic        en;
        logic [16:0] exp;   // {adc_wrb, adc_rdb, ram_wr, filter_start, ram_ptr, ram_wdata}
    } vec_t;

    function automatic vec_t mk(input int c, input logic wrb, input logic rdb, input logic wr,
                                input logic st, input logic [4:0] p, input logic [7:0] d);
        vec_t v;
        v.cyc = c;
        v.en  = 1'b1;
        v.exp = {wrb, rdb, wr, st, p, d};
        return v;
    endfunction

    vec_t vecs[11];
    int   wr0;
    int   st0;

    initial begin
        vecs[0]  = mk(0,  1, 1, 0, 0, 5'd31, 8'h00);
        vecs[1]  = mk(19, 1, 1, 0, 0, 5'd31, 8'h00);
        vecs[2]  = mk(20, 0, 1, 0, 0, 5'd31, 8'h00);
        vecs[3]  = mk(21, 0, 1, 0, 0, 5'd31, 8'h00);
        vecs[4]  = mk(22, 1, 1, 0, 0, 5'd31, 8'h00);
        vecs[5]  = mk(25, 1, 1, 0, 0, 5'd31, 8'h00);
        vecs[6]  = mk(26, 1, 0, 0, 0, 5'd31, 8'h00);
        vecs[7]  = mk(28, 1, 0, 0, 0, 5'd31, 8'h00);
        vecs[8]  = mk(29, 1, 1, 1, 0, 5'd0,  8'h5A);
        vecs[9]  = mk(30, 1, 1, 0, 1, 5'd0,  8'h5A);
        vecs[10] = mk(31, 1, 1, 0, 0, 5'd0,  8'h5A);

        // First sample timing, then 33 consecutive samples
        adc_value = 8'h5A;
        busy_len  = 8;
        start_run(1'b1);
        wr0 = wr_count;
        st0 = start_count;
        for (int i = 0; i < 11; i++) begin
            enable = vecs[i].en;
            wait_cycle(vecs[i].cyc);
            check($sformatf("s1_cyc%0d", vecs[i].cyc),
                  {15'd0, adc_wrb, adc_rdb, ram_wr, filter_start, ram_ptr, ram_wdata},
                  {15'd0, vecs[i].exp});
        end
        wait_cycle(39);
        check("s2_no_overrun", {31'd0, overrun}, 32'd0);
        wait_cycle(49);
        check("s2_second_write", {26'd0, ram_wr, ram_ptr}, {26'd0, 1'b1, 5'd1});
        for (int i = 2; i < 33; i++) begin
            wait_cycle(20 * i + 5);
            adc_value = 8'($urandom);
        end
        wait_cycle(675);
        check("s3_write_count", wr_count - wr0, 33);
        check("s3_start_count", start_count - st0, 33);
        check("s3_ptr_wrapped", {27'd0, ram_ptr}, 32'd0);
        check("s3_no_overrun", {31'd0, overrun}, 32'd0);
        check("s3_scoreboard", sb_bad, 0);

        // Long filter run: overrun, set-wins, clear
        busy_len = 40;
        start_run(1'b1);
        wr0 = wr_count;
        wait_cycle(35);
        busy_len = 8;
        wait_cycle(39);
        clear_flags = 1'b1;
        wait_cycle(40);
        clear_flags = 1'b0;
        check("s4_set_wins", {31'd0, overrun}, 32'd1);
        wait_cycle(45);
        clear_flags = 1'b1;
        wait_cycle(46);
        clear_flags = 1'b0;
        check("s4_clear", {31'd0, overrun}, 32'd0);
        wait_cycle(60);
        check("s4_overrun_again", {31'd0, overrun}, 32'd1);
        wait_cycle(85);
        check("s4_no_extra_write", wr_count - wr0, 1);
        wait_cycle(89);
        check("s4_next_write", {26'd0, ram_wr, ram_ptr}, {26'd0, 1'b1, 5'd1});
        wait_cycle(95);
        clear_flags = 1'b1;
        wait_cycle(96);
        clear_flags = 1'b0;
        check("s4_final_clear", {31'd0, overrun}, 32'd0);
        check("s4_scoreboard", sb_bad, 0);

        // A/D never answers: timeout after 10 WAIT_INT cycles, then recovery
        adc_dead = 1'b1;
        start_run(1'b1);
        wr0 = wr_count;
        st0 = start_count;
        wait_cycle(31);
        check("s5_timeout_not_yet", {31'd0, adc_timeout}, 32'd0);
        wait_cycle(32);
        check("s5_timeout_set", {31'd0, adc_timeout}, 32'd1);
        wait_cycle(35);
        adc_dead = 1'b0;
        check("s5_no_write", wr_count - wr0, 0);
        check("s5_no_start", start_count - st0, 0);
        wait_cycle(49);
        check("s5_recovered_write", {26'd0, ram_wr, ram_ptr}, {26'd0, 1'b1, 5'd0});
        wait_cycle(50);
        check("s5_flags", {30'd0, adc_timeout, overrun}, {30'd0, 2'b10});

        // Reset in the middle of READ
        start_run(1'b1);
        wait_cycle(27);
        check("s6_in_read", {31'd0, adc_rdb}, 32'd0);
        reset = 1'b1;
        wait_cycle(28);
        check("s6_after_reset", {23'd0, adc_rdb, adc_wrb, ram_wr, filter_start, ram_ptr},
              {23'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd31});
        reset = 1'b0;
        base  = pcount;
        wr0   = wr_count;
        st0   = start_count;
        wait_cycle(25);
        check("s6_no_write", wr_count - wr0, 0);
        check("s6_no_start", start_count - st0, 0);
        wait_cycle(29);
        check("s6_restart_write", {26'd0, ram_wr, ram_ptr}, {26'd0, 1'b1, 5'd0});

        // enable low holds the tick counter at zero
        start_run(1'b0);
        wait_cycle(25);
        check("s7_disabled", {31'd0, adc_wrb}, 32'd1);
        wait_cycle(30);
        enable = 1'b1;
        wait_cycle(49);
        check("s7_before_tick", {31'd0, adc_wrb}, 32'd1);
        wait_cycle(50);
        check("s7_after_tick", {31'd0, adc_wrb}, 32'd0);
        check("final_scoreboard", sb_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sample_sequencer.md
Name: sample_sequencer

Overview:
- Paces the audio filter datapath at a fixed sample rate.
- Each sample period it:
  - triggers an A/D conversion;
  - reads the converted sample;
  - writes the sample into the 32-entry circular sample RAM and advances the write pointer;
  - issues a start pulse to the convolution FSM, then waits for that FSM to finish.
- Sits between the A/D converter interface, the sample-RAM write port and filter_fsm's start/busy/ram_ptr pins.
- Flags sample overrun and A/D timeout.

Parameters:
- CLK_DIV, 1000: clk cycles per sample period (tick spacing); legal range 16..65535.
- WR_CYCLES, 2: cycles adc_wrb is held low to start a conversion.
- RD_CYCLES, 3: cycles adc_rdb is held low; data is latched on the last of them.
- CONV_TIMEOUT, 255: maximum cycles spent in WAIT_INT before the sample is abandoned.
- DATA_W, 8: sample width.
- PTR_W, 5: sample-RAM address width (depth 2^PTR_W).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  1 = generate sample ticks; 0 = tick counter held at 0
- clear_flags  in  1  single-cycle clear of the sticky flags
- adc_data  in  DATA_W  A/D output bus
- adc_intb  in  1  A/D conversion done, active low
- adc_wrb  out  1  A/D start-conversion strobe, active low
- adc_rdb  out  1  A/D output enable, active low
- ram_ptr  out  PTR_W  most recently written sample-RAM address (to filter_fsm)
- ram_wdata  out  DATA_W  sample-RAM write data
- ram_wr  out  1  sample-RAM write strobe, one cycle
- filter_start  out  1  one-cycle start pulse to filter_fsm
- filter_busy  in  1  high while the filter owns the sample RAM
- overrun  out  1  sticky: a tick arrived while not IDLE
- adc_timeout  out  1  sticky: adc_intb never asserted

Behaviour:
- All outputs are registered.
- Reset values:
  - adc_wrb=1, adc_rdb=1
  - ram_ptr = all ones (31), so the first write lands at address 0
  - ram_wdata=0, ram_wr=0, filter_start=0, overrun=0, adc_timeout=0
  - state=IDLE, tick counter=0, sub-counters=0
- Reset mid-operation aborts everything immediately. No write or start is issued on the following cycle.
- Tick generator:
  - tcnt counts 0..CLK_DIV-1 while enable=1.
  - tick=1 in the cycle where tcnt==CLK_DIV-1; tcnt then wraps to 0.
  - enable=0 forces tcnt=0 and tick=0.
- FSM states and transitions:
  - IDLE: on tick -> START_CONV. adc_wrb goes low on the next cycle.
  - START_CONV: adc_wrb=0 for WR_CYCLES cycles -> WAIT_INT.
  - WAIT_INT:
    - adc_intb==0 -> READ.
    - CONV_TIMEOUT cycles elapsed without it -> set adc_timeout, go to IDLE. No RAM write, no filter start.
  - READ: adc_rdb=0 for RD_CYCLES cycles; adc_data is captured into ram_wdata on the last low cycle -> WRITE.
  - WRITE: ram_ptr <= ram_ptr+1, wrapping 31->0; ram_wr=1 for exactly this cycle, with the new ram_ptr and ram_wdata valid -> KICK.
  - KICK: filter_start=1 for one cycle -> ARM.
  - ARM: ignore filter_busy for one cycle, since the filter registers start -> RUN.
  - RUN: filter_busy==0 -> IDLE.
- Sticky flags:
  - A tick in any state other than IDLE sets overrun. That tick is dropped and no second sample is queued.
  - The flags clear only on reset or clear_flags. If clear_flags and a set event occur in the same cycle, the set wins.
- ram_ptr changes only in WRITE. It is therefore stable throughout the filter run.
- ram_wr and filter_start are never high in the same cycle.
- ram_wr is never asserted while filter_busy=1.
- Latency from tick to ram_wr: 1 + WR_CYCLES + (cycles until adc_intb low) + RD_CYCLES + 1 cycles.

Decomposition:
- Package filter_pkg holds:
  - state encodings (IDLE, START_CONV, WAIT_INT, READ, WRITE, KICK, ARM, RUN);
  - DATA_W / PTR_W defaults, shared with filter_fsm.
- One sub-module, sample_tick_gen: the CLK_DIV counter with enable, output tick.
- Everything else lives in one FSM module.

Test Plan:
All scenarios use CLK_DIV=20, WR_CYCLES=2, RD_CYCLES=3 and CONV_TIMEOUT=10; scenarios 2 and 5 additionally rely on the A/D model (adc_intb low 4 cycles after adc_wrb rises).
1. Reset, enable=1 -> first tick at cycle 19, adc_wrb low for cycles 20-21, adc_rdb low for 3 cycles, ram_wr one cycle with ram_ptr=0, filter_start the next cycle.
2. A/D model returns 0x5A; filter model busy for 8 cycles -> ram_wdata=0x5A at ram_wr, FSM back in IDLE before the next tick, overrun=0.
3. 33 consecutive samples -> ram_ptr sequence 0..31 then 0; no gap or duplicate.
4. Filter model busy for 40 cycles -> overrun=1 after the next tick, no extra ram_wr. clear_flags pulse -> overrun=0.
5. adc_intb held high -> adc_timeout=1 after 10 WAIT_INT cycles; no ram_wr or filter_start; the next tick proceeds normally once adc_intb works.
6. Reset asserted during READ -> next cycle adc_rdb=1, state IDLE, ram_ptr=31, no ram_wr or filter_start.
